// File: rtl/instr_axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO; each entry holds tdata plus tlast. Written word is visible on m_axis one edge later.
// s_axis_tready drops when full or initialising; m_axis holds the head entry stable until m_axis_tready accepts it.
module instr_axis_fifo #(
    parameter int DATA_WIDTH      = 256,
    parameter int DEPTH           = 512,
    parameter int RST_BUSY_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  wr_rst_busy,
    output logic                  rd_rst_busy,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(RST_BUSY_CYCLES + 2);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr    = '0;
    logic [AW-1:0]       rd_ptr    = '0;
    logic [AW:0]         occupancy = '0;
    logic [BW-1:0]       busy_cnt  = BW'(RST_BUSY_CYCLES);
    logic                rst_busy  = 1'b1;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_WIDTH:0] head;

    // Ready and valid are decoded purely from registered state.
    assign s_axis_tready = (occupancy < (AW+1)'(DEPTH)) && !rst_busy;
    assign m_axis_tvalid = (occupancy != '0) && !rst_busy;
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign rd_en         = m_axis_tvalid && m_axis_tready;
    assign wr_rst_busy   = rst_busy;
    assign rd_rst_busy   = rst_busy;

    // Gate the payload so the outputs never expose uninitialised storage.
    assign head          = mem[rd_ptr];
    assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign m_axis_tlast  = m_axis_tvalid ? head[DATA_WIDTH]     : 1'b0;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   occupancy <= occupancy + (AW+1)'(1);
                2'b01:   occupancy <= occupancy - (AW+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Busy stays up through reset and RST_BUSY_CYCLES edges after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt <= BW'(RST_BUSY_CYCLES);
            rst_busy <= 1'b1;
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - BW'(1);
            rst_busy <= 1'b1;
        end else begin
            rst_busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_axis_fifo.sv
// Directed bench for instr_axis_fifo at default parameters: reset/busy, FWFT, full, wrap and reset flush.
module tb_instr_axis_fifo;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_rst_busy, rd_rst_busy;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;

    int tests_run = 0;
    int tests_failed = 0;
    int wnext, rnext;

    instr_axis_fifo dut (
        .clk(clk), .reset(reset),
        .wr_rst_busy(wr_rst_busy), .rd_rst_busy(rd_rst_busy),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW+3:0] obs, input logic [DW+3:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;

        // Reset for two cycles, then busy for three more edges.
        step(); step();
        check("rst_wr_busy", wr_rst_busy, 1);
        check("rst_rd_busy", rd_rst_busy, 1);
        check("rst_tready", s_axis_tready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("busy_hold_wr", wr_rst_busy, 1);
            check("busy_hold_rd", rd_rst_busy, 1);
            check("busy_tready", s_axis_tready, 0);
        end
        step();
        check("busy_fall_wr", wr_rst_busy, 0);
        check("busy_fall_rd", rd_rst_busy, 0);
        check("ready_after_busy", s_axis_tready, 1);
        check("tvalid_after_busy", m_axis_tvalid, 0);

        // Single word into empty FIFO, consumer stalled.
        s_axis_tvalid = 1'b1; s_axis_tdata = {32{8'hA5}}; s_axis_tlast = 1'b1;
        step();
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("fwft_valid", m_axis_tvalid, 1);
            check("fwft_data", m_axis_tdata, {32{8'hA5}});
            check("fwft_last", m_axis_tlast, 1);
            step();
        end
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("fwft_drained", m_axis_tvalid, 0);

        // Fill all 512 entries, then try a 513th.
        for (int i = 0; i < 512; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = DW'(i); s_axis_tlast = (i % 7 == 6);
            step();
        end
        s_axis_tdata = DW'(999); s_axis_tlast = 1'b1;
        check("full_tready", s_axis_tready, 0);
        step();
        check("full_tready_held", s_axis_tready, 0);
        check("full_occ", dut.occupancy, 512);
        check("full_head", m_axis_tdata, 0);

        // Drain in order; first read edge happens while full with a write pending.
        m_axis_tready = 1'b1;
        for (int i = 0; i < 512; i++) begin
            if (i == 0) check("full_read_edge_tready", s_axis_tready, 0);
            check("drain_valid", m_axis_tvalid, 1);
            check("drain_data", m_axis_tdata, DW'(i));
            check("drain_last", m_axis_tlast, (i % 7 == 6));
            step();
            if (i == 0) begin
                check("tready_after_read", s_axis_tready, 1);
                check("occ_after_read", dut.occupancy, 511);
                s_axis_tvalid = 1'b0;
            end
        end
        check("drain_empty", m_axis_tvalid, 0);
        check("drain_occ", dut.occupancy, 0);

        // Pass-through at occupancy 1 to move pointers near the wrap point.
        wnext = 3000; rnext = 3000;
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        for (int c = 0; c < 450; c++) begin
            s_axis_tdata = DW'(wnext);
            if (c == 0) check("empty_write_no_read", m_axis_tvalid, 0);
            else        check("pass_data", m_axis_tdata, DW'(rnext));
            step();
            wnext++;
            if (c > 0) rnext++;
        end
        m_axis_tready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            s_axis_tdata = DW'(wnext);
            step();
            wnext++;
        end
        check("occ_5", dut.occupancy, 5);

        // 100 cycles of simultaneous write and read at occupancy 5 across the wrap.
        m_axis_tready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            s_axis_tdata = DW'(wnext);
            check("steady_data", m_axis_tdata, DW'(rnext));
            step();
            wnext++; rnext++;
        end
        check("steady_occ", dut.occupancy, 5);
        s_axis_tvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("steady_tail", m_axis_tdata, DW'(rnext));
            step();
            rnext++;
        end
        check("steady_empty", m_axis_tvalid, 0);

        // Reset with 10 words stored.
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            s_axis_tdata = DW'(4000 + c);
            step();
        end
        check("pre_reset_occ", dut.occupancy, 10);
        s_axis_tvalid = 1'b0;
        reset = 1'b1;
        step(); step();
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_tready", s_axis_tready, 0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("post_rst_busy", wr_rst_busy, 0);
        check("post_rst_tvalid", m_axis_tvalid, 0);
        check("post_rst_tready", s_axis_tready, 1);
        s_axis_tvalid = 1'b1; s_axis_tdata = DW'(8'h77); s_axis_tlast = 1'b0;
        step();
        s_axis_tvalid = 1'b0;
        check("post_rst_first_valid", m_axis_tvalid, 1);
        check("post_rst_first_data", m_axis_tdata, DW'(8'h77));
        m_axis_tready = 1'b1;
        step();
        check("post_rst_only_word", m_axis_tvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
